// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx: a store to TX_ADDR queues a byte in a small FIFO that an
// 8N1 serializer drains onto uart_tx; STATUS_ADDR reads back {overflow, full, busy}.
module mmio_uart_tx #(
    parameter int          CLKS_PER_BIT = 868,
    parameter int          FIFO_DEPTH   = 16,
    parameter logic [31:0] TX_ADDR      = 32'hf6ff_f000,
    parameter logic [31:0] STATUS_ADDR  = 32'hf6ff_f004
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        is_store,
    input  logic [31:0] w_addr,
    input  logic [7:0]  w_data_byte,
    input  logic [31:0] r_addr,
    output logic [31:0] r_data_status,
    output logic        uart_tx,
    output logic        fifo_full,
    output logic        busy
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int BW = $clog2(CLKS_PER_BIT);
    localparam logic [PW:0]   DEPTH_C   = (PW+1)'(FIFO_DEPTH);
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t        state;
    state_t        state_nxt;
    logic [7:0]    mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW:0]   count;
    logic          overflow;
    logic [7:0]    shreg;
    logic [2:0]    bit_cnt;
    logic [BW-1:0] baud_cnt;
    logic          baud_last;
    logic          push_req;
    logic          push;
    logic          pop;
    logic          tx_nxt;

    assign push_req  = is_store && (w_addr == TX_ADDR);
    assign pop       = (state == IDLE) && (count != '0);
    assign fifo_full = (count == DEPTH_C);
    // A full FIFO still accepts a push when the serializer pops in the same cycle.
    assign push      = push_req && (!fifo_full || pop);
    assign busy      = (count != '0) || (state != IDLE);
    assign baud_last = (baud_cnt == BAUD_LAST);

    assign r_data_status = (r_addr == STATUS_ADDR) ? {29'b0, overflow, fifo_full, busy} : 32'b0;

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= w_data_byte;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      count <= count + 1'b1;
            else if (pop && !push) count <= count - 1'b1;
            if (push_req && !push) overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (count != '0) state_nxt = START;
            START:   if (baud_last) state_nxt = DATA;
            DATA:    if (baud_last && bit_cnt == 3'd7) state_nxt = STOP;
            STOP:    if (baud_last) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // The line is registered, so it is driven from the level the next state will show.
    always_comb begin
        tx_nxt = 1'b1;
        case (state_nxt)
            START:   tx_nxt = 1'b0;
            DATA:    tx_nxt = (state == DATA && baud_last) ? shreg[1] : shreg[0];
            default: tx_nxt = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            uart_tx  <= 1'b1;
            shreg    <= '0;
            bit_cnt  <= '0;
            baud_cnt <= '0;
        end else begin
            uart_tx <= tx_nxt;
            if (state == IDLE) begin
                baud_cnt <= '0;
                if (pop) begin
                    shreg   <= mem[rd_ptr];
                    bit_cnt <= '0;
                end
            end else begin
                baud_cnt <= baud_last ? '0 : baud_cnt + 1'b1;
                if (state == DATA && baud_last) begin
                    shreg   <= shreg >> 1;
                    bit_cnt <= bit_cnt + 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_mmio_uart_tx.sv
// Bench for mmio_uart_tx: a queue/frame-timer reference model predicts accepted
// bytes and start times; a line monitor decodes frames and checks them against it.
module tb_mmio_uart_tx;
    localparam int          CPB    = 4;
    localparam int          DEPTH  = 4;
    localparam logic [31:0] TXA    = 32'hf6ff_f000;
    localparam logic [31:0] STA    = 32'hf6ff_f004;
    localparam int          FRAME  = 10 * CPB;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        is_store = 1'b0;
    logic [31:0] w_addr = '0;
    logic [7:0]  w_data_byte = '0;
    logic [31:0] r_addr = STA;
    logic [31:0] r_data_status;
    logic        uart_tx;
    logic        fifo_full;
    logic        busy;

    mmio_uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH), .TX_ADDR(TXA), .STATUS_ADDR(STA)) dut (
        .clk(clk), .reset(reset), .is_store(is_store), .w_addr(w_addr),
        .w_data_byte(w_data_byte), .r_addr(r_addr), .r_data_status(r_data_status),
        .uart_tx(uart_tx), .fifo_full(fifo_full), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct { logic [7:0] b; int c; } frame_t;

    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    logic [7:0] mq[$];
    frame_t     exp_q[$];
    int         timer = 0;
    logic       m_ovf = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors < 40) $display("FAIL %s act=%0h exp=%0h cyc=%0d", nm, act, exp, cyc);
        end
    endtask

    // Reference model: bytes waiting, plus cycles left in the frame on the wire.
    always @(posedge clk) begin
        logic   pop, req, acc;
        frame_t f;
        cyc++;
        if (reset) begin
            mq.delete();
            exp_q.delete();
            timer = 0;
            m_ovf = 1'b0;
        end else begin
            pop = (timer == 0) && (mq.size() > 0);
            req = is_store && (w_addr == TXA);
            acc = req && ((mq.size() < DEPTH) || pop);
            if (req && !acc) m_ovf = 1'b1;
            if (pop) begin
                f.b = mq.pop_front();
                f.c = cyc;
                exp_q.push_back(f);
                timer = FRAME;
            end else if (timer > 0) begin
                timer--;
            end
            if (acc) mq.push_back(w_data_byte);
        end
    end

    function automatic logic m_busy();
        return (mq.size() > 0) || (timer > 0);
    endfunction

    // Per-cycle flag/status checks.
    always @(negedge clk) begin
        logic        full;
        logic [31:0] st;
        if (cyc > 0) begin
            full = (mq.size() == DEPTH);
            st   = (r_addr == STA) ? {29'b0, m_ovf, full, m_busy()} : 32'b0;
            chk("busy", busy, m_busy());
            chk("fifo_full", fifo_full, full);
            chk("status", r_data_status, st);
            if (timer == 0) chk("tx_idle", uart_tx, 1);
        end
    end

    // Line monitor: decodes each frame and pops the scoreboard.
    logic       mon_on = 1'b0;
    int         mon_k = 0;
    int         mon_start = 0;
    logic [7:0] mon_byte = '0;
    always @(negedge clk) begin
        frame_t e;
        if (reset) begin
            mon_on = 1'b0;
        end else if (cyc > 0) begin
            if (!mon_on && uart_tx === 1'b0) begin
                mon_on = 1'b1;
                mon_k = 0;
                mon_start = cyc;
                mon_byte = '0;
            end
            if (mon_on) begin
                if (mon_k < CPB) chk("start_bit", uart_tx, 0);
                else if (mon_k < 9 * CPB) begin
                    if (mon_k % CPB == 0) mon_byte[(mon_k - CPB) / CPB] = uart_tx;
                    else chk("bit_hold", uart_tx, mon_byte[(mon_k - CPB) / CPB]);
                end else chk("stop_bit", uart_tx, 1);
                if (mon_k == FRAME - 1) begin
                    mon_on = 1'b0;
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_frame act=%0h exp=none cyc=%0d", mon_byte, cyc);
                    end else begin
                        e = exp_q.pop_front();
                        chk("frame_byte", mon_byte, e.b);
                        chk("frame_start", mon_start, e.c);
                    end
                end
                mon_k++;
            end
        end
    end

    task automatic step(input logic st, input logic [31:0] a, input logic [7:0] d);
        is_store = st;
        w_addr = a;
        w_data_byte = d;
        @(posedge clk);
        #1;
        is_store = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 32'h0, 8'h0);
    endtask

    task automatic wait_idle(input int lim);
        int n;
        n = 0;
        while ((m_busy() || mon_on) && n < lim) begin
            step(1'b0, 32'h0, 8'h0);
            n++;
        end
        checks++;
        if (n >= lim) begin
            errors++;
            $display("FAIL wait_idle_timeout act=%0d exp=<%0d", n, lim);
        end
        idle(3);
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        idle(n);
        reset = 1'b0;
    endtask

    initial begin
        int n;
        do_reset(2);
        chk("rst_tx", uart_tx, 1);
        chk("rst_busy", busy, 0);
        chk("rst_full", fifo_full, 0);
        chk("rst_status", r_data_status, 0);
        idle(2);

        step(1'b1, TXA, 8'hA5);
        wait_idle(200);

        step(1'b1, TXA, 8'h00);
        step(1'b1, TXA, 8'hFF);
        wait_idle(300);

        for (int i = 0; i < 6; i++) step(1'b1, TXA, 8'h30 + 8'(i));
        chk("ovf_status", r_data_status, 32'h7);
        wait_idle(600);
        chk("ovf_sticky", r_data_status, 32'h4);

        do_reset(1);
        step(1'b1, TXA, 8'h11);
        for (int i = 0; i < DEPTH; i++) step(1'b1, TXA, 8'h20 + 8'(i));
        n = 0;
        while (!(timer == 0 && mq.size() == DEPTH) && n < 200) begin
            idle(1);
            n++;
        end
        chk("swap_reached", (n < 200), 1);
        step(1'b1, TXA, 8'h5A);
        chk("swap_full", fifo_full, 1);
        chk("swap_no_ovf", r_data_status[2], 0);
        wait_idle(800);

        step(1'b1, TXA, 8'h81);
        step(1'b1, TXA, 8'h82);
        step(1'b1, TXA, 8'h83);
        n = 0;
        while (timer != 22 && n < 100) begin
            idle(1);
            n++;
        end
        chk("midrst_reached", (n < 100), 1);
        reset = 1'b1;
        idle(1);
        reset = 1'b0;
        chk("midrst_tx", uart_tx, 1);
        chk("midrst_busy", busy, 0);
        idle(100);
        chk("midrst_busy_late", busy, 0);

        r_addr = TXA;
        step(1'b1, TXA + 32'd8, 8'h55);
        chk("decode_status", r_data_status, 0);
        chk("decode_busy", busy, 0);
        idle(5);
        r_addr = STA;

        for (int i = 0; i < 400; i++) begin
            case ($urandom_range(0, 3))
                0: r_addr = TXA;
                1: r_addr = 32'h0;
                default: r_addr = STA;
            endcase
            step(($urandom_range(0, 5) == 0),
                 ($urandom_range(0, 3) == 0) ? ((($urandom & 1) != 0) ? STA : TXA + 32'd4) : TXA,
                 8'($urandom));
        end
        r_addr = STA;
        wait_idle(2000);
        chk("scoreboard_empty", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mmio_uart_tx.md
# mmio_uart_tx

Memory-mapped UART transmitter on the CPU store path, downstream of the load/store unit alongside the data memory. A store to `TX_ADDR` pushes the low byte of the store data into an internal FIFO. A serializer drains the FIFO onto `uart_tx` as 8N1 frames. A status word at `STATUS_ADDR` is readable combinationally so software can poll for space or completion.

## Interface
- `CLKS_PER_BIT`, 868: clock cycles per UART bit (100 MHz / 115200); legal ≥ 2.
- `FIFO_DEPTH`, 16: FIFO entries; power of two, ≥ 2.
- `TX_ADDR`, 32'hf6fff000: store address that pushes a byte.
- `STATUS_ADDR`, 32'hf6fff004: read address of the status word.

- `clk`  in  1  system clock; single clock domain. Reset is synchronous and active-high.
- `reset`  in  1  synchronous, active-high reset.
- `is_store`  in  1  current instruction is a store.
- `w_addr`  in  32  store address from the LSU.
- `w_data_byte`  in  8  low byte of store data from the LSU.
- `r_addr`  in  32  load address from the LSU.
- `r_data_status`  out  32  status word, combinational.
- `uart_tx`  out  1  serial line, registered; idle high.
- `fifo_full`  out  1  FIFO holds `FIFO_DEPTH` entries.
- `busy`  out  1  FIFO non-empty or serializer not in IDLE.

## Operation
- Push:
  - Condition: `is_store && w_addr == TX_ADDR`, sampled at the rising edge of `clk`.
  - The store width (SB/SH/SW) is irrelevant; only `w_data_byte` is queued.
- Overflow:
  - A push while full with no pop in the same cycle drops the byte and sets sticky `overflow`.
  - `overflow` clears only on reset.
- FIFO: circular buffer with `log2(FIFO_DEPTH)`-bit read and write pointers that wrap modulo depth, plus a count of width `log2(FIFO_DEPTH)+1`.
- Simultaneous push and pop:
  - When full, the push is accepted and the count is unchanged.
  - When empty, a pop cannot occur because IDLE only pops on count > 0.
- Status word: `r_data_status = {29'b0, overflow, fifo_full, busy}` when `r_addr == STATUS_ADDR`, else 32'b0.
- Serializer FSM, states IDLE, START, DATA, STOP:
  - IDLE: `uart_tx` = 1. If count > 0: pop the head into `shreg`, clear the bit counter and baud counter, go to START.
  - START: `uart_tx` = 0 for `CLKS_PER_BIT` cycles, then go to DATA.
  - DATA: `uart_tx` = `shreg[0]`. Every `CLKS_PER_BIT` cycles, shift right and increment the bit counter. After bit 7 completes, go to STOP. Bits go out LSB first.
  - STOP: `uart_tx` = 1 for `CLKS_PER_BIT` cycles, then go to IDLE.
- Baud counter runs 0..`CLKS_PER_BIT`-1 and wraps to 0 on each state or bit advance.
- Reset values:
  - `uart_tx` = 1, state IDLE, pointers and count 0, `overflow` 0, `shreg` 0.
  - Outputs after reset: `fifo_full` 0, `busy` 0, `r_data_status` 0.
- Reset mid-frame aborts the frame. `uart_tx` is high after the reset edge and FIFO contents are discarded.

## Timing
- Store committed at edge N: entry visible at edge N. `busy` rises after edge N.
- If the FSM was IDLE with an empty FIFO, it pops at edge N+1. `uart_tx` falls after edge N+1.
- A frame holds `uart_tx` for exactly 10×`CLKS_PER_BIT` cycles: start, 8 data bits, stop.
- Back-to-back bytes: one IDLE cycle between the end of STOP and the next start bit. Period per byte is 10×`CLKS_PER_BIT`+1 cycles.
- `busy` falls after the edge that enters IDLE with count 0.
- `fifo_full` and `busy` derive combinationally from registered state; no extra latency.

## Test plan
All scenarios use `CLKS_PER_BIT`=4 and `FIFO_DEPTH`=4.
- Reset: hold `reset` 2 cycles, then release.
  - Expect `uart_tx`=1, `busy`=0, `fifo_full`=0.
  - Read `STATUS_ADDR` → 0x00000000.
- Single byte: store 0xA5 to `TX_ADDR`.
  - `uart_tx` falls 1 cycle after the commit edge.
  - Line sequence, each level held 4 cycles: 0,1,0,1,0,0,1,0,1,1.
  - `busy` deasserts 41 cycles after the commit edge.
- Back-to-back: store 0x00 then 0xFF on consecutive cycles.
  - Two frames separated by exactly one high IDLE cycle.
  - Second start bit begins 41 cycles after the first.
- Full and overflow: store 6 bytes in 6 consecutive cycles starting from idle.
  - The first byte is popped, so 4 fit in the FIFO. `fifo_full`=1.
  - The 6th is dropped; status reads 0x7.
  - Only 5 frames are emitted and `overflow` stays 1.
- Push while full with simultaneous pop: fill the FIFO during a frame, then push on the cycle the FSM enters IDLE.
  - Push accepted; `fifo_full` stays 1; no overflow.
- Mid-frame reset: assert `reset` during DATA bit 3 with 2 bytes queued.
  - `uart_tx`=1 after the reset edge.
  - No further frames are emitted and `busy`=0.
- Address decode: store to `TX_ADDR`+8 and read `r_addr`=`TX_ADDR`.
  - No push occurs and `r_data_status`=0.
